fetch_pc_unit: RTL and testbench

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

---
 rtl/fetch_pkg.sv | 15 +
 rtl/return_addr_stack.sv | 52 +++++
 rtl/fetch_pc_unit.sv | 116 +++++++++++
 tb/tb_fetch_pc_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared PC-select encoding and XLEN-independent constants for the fetch PC unit.
package fetch_pkg;

    typedef enum logic [2:0] {
        TRAP,
        JALR,
        JMP,
        RAS,
        INC
    } pc_sel_t;

    localparam int unsigned INC_FULL = 4;
    localparam int unsigned INC_COMP = 2;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack: a push when full silently overwrites the oldest entry.
module return_addr_stack #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [XLEN-1:0]              data,
    output logic [XLEN-1:0]              top,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] ptr;

    assign top   = mem[ptr];
    assign empty = (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (push && !pop) begin
            ptr   <= ptr + PTR_W'(1);
            count <= (count == CNT_W'(DEPTH)) ? count : count + CNT_W'(1);
        end else if (pop && !push) begin
            ptr   <= ptr - PTR_W'(1);
            count <= count - CNT_W'(1);
        end
    end

    // NOTE: the entries carry no reset; count alone marks validity, so the array stays plain RAM.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (push && pop) begin
                mem[ptr] <= data;
            end else if (push) begin
                mem[ptr + PTR_W'(1)] <= data;
            end
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch program counter with trap/jalr/jump redirects and an optional return-address stack.
// The stack is built only when FETCH_PC_RAS_EN is defined; otherwise call/ret are ignored.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            instr_comp,
    input  logic            jmp_enable,
    input  logic [XLEN-1:0] jmp_offset,
    input  logic            jalr_enable,
    input  logic [XLEN-1:0] jalr_target,
    input  logic            trap_enable,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            call,
    input  logic            ret,
    output logic [XLEN-1:0] curr_addr,
    output logic [XLEN-1:0] inc_addr,
    output logic [XLEN-1:0] next_addr,
    output logic            misaligned,
    output logic            ras_empty
);

    pc_sel_t         sel;
    logic [XLEN-1:0] jmp_target;
    logic [XLEN-1:0] jalr_aligned;
    logic [XLEN-1:0] ras_top;
    logic            advance;
    logic            misalign_jmp;
    logic            unused_jalr_lsb;

    assign inc_addr        = curr_addr + (instr_comp ? XLEN'(INC_COMP) : XLEN'(INC_FULL));
    assign jmp_target      = curr_addr + jmp_offset;
    assign jalr_aligned    = {jalr_target[XLEN-1:1], 1'b0};
    assign unused_jalr_lsb = jalr_target[0];
    assign advance         = ~stall & ~trap_enable;

`ifdef FETCH_PC_RAS_EN
    logic                           push;
    logic                           pop;
    logic [$clog2(RAS_DEPTH+1)-1:0] ras_count_unused;

    // Only a taken call pushes its link; a return pops whether or not it wins selection.
    assign push = call & advance & (jmp_enable | jalr_enable);
    assign pop  = ret & advance & ~ras_empty;

    return_addr_stack #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (trap_enable),
        .data  (inc_addr),
        .top   (ras_top),
        .empty (ras_empty),
        .count (ras_count_unused)
    );
`else
    logic unused_ras_hints;

    assign unused_ras_hints = call ^ ret;
    assign ras_top          = '0;
    assign ras_empty        = 1'b1;
`endif

    // NOTE: default assignment first keeps this purely combinational with no inferred latch.
    always_comb begin
        sel = INC;
        if (trap_enable) begin
            sel = TRAP;
        end else if (jalr_enable) begin
            sel = JALR;
        end else if (jmp_enable) begin
            sel = JMP;
        end else if (ret && !ras_empty) begin
            sel = RAS;
        end
    end

    always_comb begin
        next_addr = inc_addr;
        case (sel)
            TRAP:    next_addr = trap_vector;
            JALR:    next_addr = jalr_aligned;
            JMP:     next_addr = jmp_target;
            RAS:     next_addr = ras_top;
            default: next_addr = inc_addr;
        endcase
    end

    assign misalign_jmp = (sel == JMP) & jmp_target[0];

    // A trap redirects even under stall; an odd jump target leaves the PC where it is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            curr_addr  <= RESET_VECTOR;
            misaligned <= 1'b0;
        end else begin
            misaligned <= advance & misalign_jmp;
            if (trap_enable) begin
                curr_addr <= next_addr;
            end else if (!stall && !misalign_jmp) begin
                curr_addr <= next_addr;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_fetch_pc_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
`ifdef FETCH_PC_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            stall = 1'b0;
    logic            instr_comp = 1'b0;
    logic            jmp_enable = 1'b0;
    logic [XLEN-1:0] jmp_offset = '0;
    logic            jalr_enable = 1'b0;
    logic [XLEN-1:0] jalr_target = '0;
    logic            trap_enable = 1'b0;
    logic [XLEN-1:0] trap_vector = '0;
    logic            call = 1'b0;
    logic            ret = 1'b0;
    logic [XLEN-1:0] curr_addr;
    logic [XLEN-1:0] inc_addr;
    logic [XLEN-1:0] next_addr;
    logic            misaligned;
    logic            ras_empty;

    fetch_pc_unit #(
        .XLEN         (XLEN),
        .RESET_VECTOR (32'h0000_0000),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .instr_comp  (instr_comp),
        .jmp_enable  (jmp_enable),
        .jmp_offset  (jmp_offset),
        .jalr_enable (jalr_enable),
        .jalr_target (jalr_target),
        .trap_enable (trap_enable),
        .trap_vector (trap_vector),
        .call        (call),
        .ret         (ret),
        .curr_addr   (curr_addr),
        .inc_addr    (inc_addr),
        .next_addr   (next_addr),
        .misaligned  (misaligned),
        .ras_empty   (ras_empty)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: PC value, misalign flag, and the stack as a queue (newest at the back).
    logic [31:0] m_pc = 32'h0;
    bit          m_mis = 1'b0;
    logic [31:0] m_ras[$];
    logic [31:0] m_next, m_inc, m_jt;

    task automatic model_reset();
        m_pc  = 32'h0;
        m_mis = 1'b0;
        m_ras.delete();
    endtask

    // Apply inputs at the falling edge and predict the combinational next PC.
    task automatic drive(input bit st, input bit comp, input bit jm, input logic [31:0] joff,
                         input bit jr, input logic [31:0] jt, input bit tr, input logic [31:0] tv,
                         input bit c, input bit r);
        @(negedge clk);
        stall = st; instr_comp = comp; jmp_enable = jm; jmp_offset = joff;
        jalr_enable = jr; jalr_target = jt; trap_enable = tr; trap_vector = tv;
        call = c; ret = r;
        m_inc = m_pc + (comp ? 32'd2 : 32'd4);
        m_jt  = m_pc + joff;
        if (tr)                          m_next = tv;
        else if (jr)                     m_next = jt & 32'hFFFF_FFFE;
        else if (jm)                     m_next = m_jt;
        else if (r && m_ras.size() != 0) m_next = m_ras[m_ras.size()-1];
        else                             m_next = m_inc;
        #1;
    endtask

    task automatic tick();
        bit push, pop;
        @(posedge clk);
        m_mis = 1'b0;
        if (trap_enable) begin
            m_pc = trap_vector;
            m_ras.delete();
        end else if (!stall) begin
            push = RAS_EN && call && (jmp_enable || jalr_enable);
            pop  = RAS_EN && ret && m_ras.size() != 0;
            if (!jalr_enable && jmp_enable && m_jt[0]) m_mis = 1'b1;
            else                                       m_pc  = m_next;
            if (push && pop) begin
                m_ras[m_ras.size()-1] = m_inc;
            end else if (push) begin
                m_ras.push_back(m_inc);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end else if (pop) begin
                void'(m_ras.pop_back());
            end
        end
        #1;
    endtask

    task automatic plain();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 32'h40, 0, 0, 0, 0, 1, 0);
            tick();
        end
        @(negedge clk);
        #2;
        stall = 0; jmp_enable = 0; call = 0; ret = 0;
        rst = 1'b1; trap_enable = 1'b1; trap_vector = 32'h500;
        #1;
        n_vec++; if (curr_addr !== 32'h0) begin n_err++; $display("FAIL reset_async: curr_addr got %h expected %h", curr_addr, 32'h0); end
        n_vec++; if (misaligned !== 1'b0) begin n_err++; $display("FAIL reset_mis: got %b expected 0", misaligned); end
        n_vec++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL reset_ras_empty: got %b expected 1", ras_empty); end
        @(posedge clk);
        #1;
        n_vec++; if (curr_addr !== 32'h0) begin n_err++; $display("FAIL reset_hold: curr_addr got %h expected %h", curr_addr, 32'h0); end
        #1;
        rst = 1'b0; trap_enable = 1'b0; trap_vector = '0;
        model_reset();
        for (int i = 1; i <= 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            n_vec++; if (next_addr !== 32'(i * 4)) begin n_err++; $display("FAIL reset_seq_next[%0d]: got %h expected %h", i, next_addr, 32'(i * 4)); end
            tick();
            n_vec++; if (curr_addr !== 32'(i * 4)) begin n_err++; $display("FAIL reset_seq[%0d]: got %h expected %h", i, curr_addr, 32'(i * 4)); end
        end
    endtask

    task automatic test_priority();
        drive(0, 0, 1, 32'h40, 0, 0, 0, 0, 1, 0);
        tick();
        drive(1, 0, 1, 32'h8, 1, 32'h200, 1, 32'h100, 1, 1);
        n_vec++; if (next_addr !== 32'h100) begin n_err++; $display("FAIL prio_next: got %h expected %h", next_addr, 32'h100); end
        tick();
        n_vec++; if (curr_addr !== 32'h100) begin n_err++; $display("FAIL prio_curr: got %h expected %h", curr_addr, 32'h100); end
        n_vec++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL prio_flush: ras_empty got %b expected 1", ras_empty); end
    endtask

    task automatic test_misalign();
        drive(0, 0, 0, 0, 1, 32'h21, 0, 0, 0, 0);
        n_vec++; if (next_addr !== 32'h20) begin n_err++; $display("FAIL jalr_lsb: got %h expected %h", next_addr, 32'h20); end
        tick();
        drive(0, 0, 1, 32'h3, 0, 0, 0, 0, 0, 0);
        n_vec++; if (next_addr !== 32'h23) begin n_err++; $display("FAIL mis_next: got %h expected %h", next_addr, 32'h23); end
        tick();
        n_vec++; if (curr_addr !== 32'h20) begin n_err++; $display("FAIL mis_hold: got %h expected %h", curr_addr, 32'h20); end
        n_vec++; if (misaligned !== 1'b1) begin n_err++; $display("FAIL mis_flag: got %b expected 1", misaligned); end
        plain();
        n_vec++; if (misaligned !== 1'b0) begin n_err++; $display("FAIL mis_clear: got %b expected 0", misaligned); end
        n_vec++; if (curr_addr !== 32'h24) begin n_err++; $display("FAIL mis_resume: got %h expected %h", curr_addr, 32'h24); end
    endtask

    task automatic test_call_ret();
        logic [31:0] exp;
        drive(0, 0, 0, 0, 0, 0, 1, 32'h40, 0, 0);
        tick();
        drive(0, 0, 1, 32'h100, 0, 0, 0, 0, 1, 0);
        tick();
        n_vec++; if (curr_addr !== 32'h140) begin n_err++; $display("FAIL call_target: got %h expected %h", curr_addr, 32'h140); end
        n_vec++; if (ras_empty !== !RAS_EN) begin n_err++; $display("FAIL call_push: ras_empty got %b expected %b", ras_empty, !RAS_EN); end
        plain();
        plain();
        exp = RAS_EN ? 32'h44 : 32'h14C;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        n_vec++; if (next_addr !== exp) begin n_err++; $display("FAIL ret_next: got %h expected %h", next_addr, exp); end
        tick();
        n_vec++; if (curr_addr !== exp) begin n_err++; $display("FAIL ret_curr: got %h expected %h", curr_addr, exp); end
        n_vec++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL ret_empty: got %b expected 1", ras_empty); end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_pc, exp;
        drive(0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0);
        tick();
        for (int i = 0; i <= DEPTH; i++) begin
            drive(0, 0, 0, 0, 1, 32'((i + 1) * 16), 0, 0, 1, 0);
            tick();
            n_vec++; if (curr_addr !== 32'((i + 1) * 16)) begin n_err++; $display("FAIL ovf_call[%0d]: got %h expected %h", i, curr_addr, 32'((i + 1) * 16)); end
        end
        exp_pc = 32'((DEPTH + 1) * 16);
        for (int k = 0; k < DEPTH; k++) begin
            exp = RAS_EN ? 32'((DEPTH - k) * 16 + 4) : exp_pc + 32'd4;
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            tick();
            n_vec++; if (curr_addr !== exp) begin n_err++; $display("FAIL ovf_ret[%0d]: got %h expected %h", k, curr_addr, exp); end
            exp_pc = exp;
        end
        n_vec++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL ovf_drained: ras_empty got %b expected 1", ras_empty); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        n_vec++; if (next_addr !== exp_pc + 32'd4) begin n_err++; $display("FAIL ovf_fall: got %h expected %h", next_addr, exp_pc + 32'd4); end
        tick();
    endtask

    task automatic test_wrap();
        drive(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_vec++; if (next_addr !== 32'h0) begin n_err++; $display("FAIL wrap_fc: got %h expected %h", next_addr, 32'h0); end
        tick();
        n_vec++; if (curr_addr !== 32'h0) begin n_err++; $display("FAIL wrap_fc_curr: got %h expected %h", curr_addr, 32'h0); end
        drive(0, 0, 0, 0, 1, 32'hFFFF_FFFE, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_vec++; if (inc_addr !== 32'h2) begin n_err++; $display("FAIL wrap_fe: got %h expected %h", inc_addr, 32'h2); end
        tick();
        drive(0, 0, 1, 32'hFFFF_FFF8, 0, 0, 0, 0, 0, 0);
        tick();
        n_vec++; if (curr_addr !== 32'hFFFF_FFFA) begin n_err++; $display("FAIL wrap_neg_jmp: got %h expected %h", curr_addr, 32'hFFFF_FFFA); end
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        n_vec++; if (inc_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL comp_inc: got %h expected %h", inc_addr, 32'hFFFF_FFFC); end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit st, comp, jm, jr, tr, c, r;
            logic [31:0] joff, jt, tv;
            st   = ($urandom_range(0, 9) < 2);
            comp = $urandom_range(0, 1) == 1;
            jm   = ($urandom_range(0, 9) < 2);
            jr   = ($urandom_range(0, 9) == 0);
            tr   = ($urandom_range(0, 29) == 0);
            c    = ($urandom_range(0, 3) == 0);
            r    = ($urandom_range(0, 3) == 0);
            joff = ($urandom & 32'h0000_0FFE) - 32'h800;
            jt   = $urandom & 32'h0000_FFFF;
            tv   = $urandom & 32'h0000_FFFC;
            if ($urandom_range(0, 9) == 0) begin
                joff = joff | 32'h1;
                c = 1'b0;
                r = 1'b0;
            end
            drive(st, comp, jm, joff, jr, jt, tr, tv, c, r);
            n_vec++; if (next_addr !== m_next) begin n_err++; $display("FAIL rand_next[%0d]: got %h expected %h", i, next_addr, m_next); end
            n_vec++; if (inc_addr !== m_inc) begin n_err++; $display("FAIL rand_inc[%0d]: got %h expected %h", i, inc_addr, m_inc); end
            tick();
            n_vec++; if (curr_addr !== m_pc) begin n_err++; $display("FAIL rand_curr[%0d]: got %h expected %h", i, curr_addr, m_pc); end
            n_vec++; if (misaligned !== m_mis) begin n_err++; $display("FAIL rand_mis[%0d]: got %b expected %b", i, misaligned, m_mis); end
            n_vec++; if (ras_empty !== (m_ras.size() == 0)) begin n_err++; $display("FAIL rand_empty[%0d]: got %b expected %b", i, ras_empty, m_ras.size() == 0); end
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        n_vec++; if (curr_addr !== 32'h0) begin n_err++; $display("FAIL init_reset: curr_addr got %h expected %h", curr_addr, 32'h0); end
        test_reset();
        test_priority();
        test_misalign();
        test_call_ret();
        test_overflow();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
